// File: rtl/edge_pattern_pkg.sv
// rtl/edge_pattern_pkg.sv - shared types and default widths for the edge pattern generator
// Purpose: FSM state encoding and default counter widths used by the generator
//          and its interval counter.
package edge_pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CNT_W_DEF  = 16;
  localparam int EDGE_W_DEF = 8;

endpackage

// File: rtl/interval_counter.sv
// rtl/interval_counter.sv - loadable down-counter with zero flag
// Purpose: counts cycles between toggles; saturates at zero instead of wrapping.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset (value -> 0)
//   load       in   load load_value this cycle (wins over dec)
//   load_value in   W  value to load
//   dec        in   decrement by one when nonzero
//   value      out  W  current count
//   zero       out  count equals zero
module interval_counter
  import edge_pattern_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/edge_pattern_generator.sv
// rtl/edge_pattern_generator.sv - square-wave generator producing N toggles at H-cycle spacing
// Purpose: accepts {half_period, num_edges} on start while idle, then toggles
//          out N times, one toggle every max(H,1) cycles, flagging each with edge_tick.
// Ports:
//   clk, rst     in   clock, asynchronous active-high reset
//   start        in   command request, sampled only while idle
//   half_period  in   CNT_W   cycles between toggles (0 behaves as 1)
//   num_edges    in   EDGE_W  number of toggles (0 completes immediately)
//   abort        in   stop the current run without done
//   out          out  generated level (registered)
//   edge_tick    out  one-cycle pulse coincident with each change of out
//   busy         out  high while a run is active
//   done         out  one-cycle pulse on normal completion
module edge_pattern_generator
  import edge_pattern_pkg::*;
#(
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   EDGE_W     = EDGE_W_DEF,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [EDGE_W-1:0] num_edges,
  input  logic              abort,
  output logic              out,
  output logic              edge_tick,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic               out_q, out_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic [EDGE_W-1:0]  left_q, left_d;
  logic [CNT_W-1:0]   heff_q, heff_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_value;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_value;
  logic               cnt_zero;

  interval_counter #(.W(CNT_W)) u_interval (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    out_d          = out_q;
    tick_d         = 1'b0;
    done_d         = 1'b0;
    left_d         = left_q;
    heff_d         = heff_q;
    cnt_load       = 1'b0;
    cnt_load_value = heff_q - CNT_W'(1);
    cnt_dec        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort is meaningless here, so start+abort still launches a run
        if (start) begin
          if (num_edges == '0) begin
            done_d = 1'b1;
          end else begin
            heff_d         = (half_period == '0) ? CNT_W'(1) : half_period;
            cnt_load       = 1'b1;
            cnt_load_value = heff_d - CNT_W'(1);
            left_d         = num_edges;
            state_d        = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // abort beats a toggle due on the same edge
          state_d = IDLE;
        end else if (cnt_zero) begin
          out_d    = ~out_q;
          tick_d   = 1'b1;
          cnt_load = 1'b1;
          if (left_q == EDGE_W'(1)) begin
            // last toggle: done shares the edge; left stays at 1
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            left_d = left_q - EDGE_W'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= IDLE_LEVEL;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      heff_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      left_q  <= left_d;
      heff_q  <= heff_d;
    end
  end

  assign out       = out_q;
  assign edge_tick = tick_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_edge_pattern_generator.sv
// tb/tb_edge_pattern_generator.sv - directed vector bench for edge_pattern_generator
module tb_edge_pattern_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] half_period = '0;
  logic [7:0]  num_edges = '0;
  logic        abort = 1'b0;
  logic        out;
  logic        edge_tick;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic lvl = 1'b0;

  edge_pattern_generator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .half_period (half_period),
    .num_edges   (num_edges),
    .abort       (abort),
    .out         (out),
    .edge_tick   (edge_tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   h;
    int   n;
    bit   ab;
    logic fin;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input int j, input logic eb, input logic ed,
                           input logic et, input logic eo);
    chk($sformatf("%s busy j=%0d", tag, j), {31'd0, busy}, {31'd0, eb});
    chk($sformatf("%s done j=%0d", tag, j), {31'd0, done}, {31'd0, ed});
    chk($sformatf("%s tick j=%0d", tag, j), {31'd0, edge_tick}, {31'd0, et});
    chk($sformatf("%s out j=%0d", tag, j), {31'd0, out}, {31'd0, eo});
  endtask

  // Applies one command and checks every cycle against a closed-form timeline.
  // While busy, start is pulsed with random H/N to prove they are ignored.
  task automatic run_cmd(input int idx, input int h, input int n, input bit ab, input logic fin);
    int heff;
    int total;
    logic et;
    heff  = (h == 0) ? 1 : h;
    total = n * heff;
    @(negedge clk);
    half_period = 16'(h);
    num_edges   = 8'(n);
    start       = 1'b1;
    abort       = ab;
    @(posedge clk);
    for (int j = 0; j <= total + 2; j++) begin
      @(negedge clk);
      abort = 1'b0;
      start = (j >= 1) && (j <= total - 2);
      if (start) begin
        half_period = 16'($urandom_range(1, 9));
        num_edges   = 8'($urandom_range(1, 9));
      end
      et = (n > 0) && (j >= 1) && (j % heff == 0) && (j <= total);
      if (et) lvl = ~lvl;
      chk_cycle($sformatf("vec%0d", idx), j, (n > 0) && (j < total),
                (n == 0) ? (j == 0) : (j == total), et, lvl);
    end
    chk($sformatf("vec%0d final_out", idx), {31'd0, out}, {31'd0, fin});
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{h: 3, n: 4, ab: 1'b0, fin: 1'b0};
    vecs[1] = '{h: 0, n: 3, ab: 1'b0, fin: 1'b1};
    vecs[2] = '{h: 1, n: 2, ab: 1'b0, fin: 1'b1};
    vecs[3] = '{h: 7, n: 0, ab: 1'b0, fin: 1'b1};
    vecs[4] = '{h: 2, n: 1, ab: 1'b0, fin: 1'b0};
    vecs[5] = '{h: 4, n: 5, ab: 1'b0, fin: 1'b1};
    vecs[6] = '{h: 1, n: 1, ab: 1'b1, fin: 1'b0};
    vecs[7] = '{h: 5, n: 2, ab: 1'b0, fin: 1'b0};

    // reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cycle("reset_hold", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_cycle("reset_rel", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    lvl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_cmd(i, vecs[i].h, vecs[i].n, vecs[i].ab, vecs[i].fin);
    end

    // start held through done: second run accepted on the edge after done
    @(negedge clk);
    half_period = 16'd2;
    num_edges   = 8'd2;
    start       = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 10; j++) begin
      logic et;
      @(negedge clk);
      if (j == 5) start = 1'b0;
      et = (j == 2) || (j == 4) || (j == 7) || (j == 9);
      if (et) lvl = ~lvl;
      chk_cycle("b2b", j, (j < 4) || (j >= 5 && j < 9), (j == 4) || (j == 9), et, lvl);
    end

    // abort on the edge where toggle 2 is due
    @(negedge clk);
    half_period = 16'd2;
    num_edges   = 8'd5;
    start       = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 8; j++) begin
      logic et;
      @(negedge clk);
      start = 1'b0;
      abort = (j == 3);
      et = (j == 2);
      if (et) lvl = ~lvl;
      chk_cycle("abort", j, j < 4, 1'b0, et, lvl);
    end

    // asynchronous reset after 2 of 6 toggles
    @(negedge clk);
    half_period = 16'd2;
    num_edges   = 8'd6;
    start       = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrun pre_tick", {31'd0, edge_tick}, 32'd1);
    chk("midrun pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_cycle("midrun_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    lvl = 1'b0;
    run_cmd(8, 3, 1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
